// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, load-data extraction and writeback
// select. Drives the register-file write port and the EX forwarding path, and
// counts retired instructions. The RF writes on negedge, so a write issued
// here lands in the same cycle the instruction occupies WB.
module mem_wb_stage #(
  parameter int CNT_W      = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_rfwr,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wdsel,
  input  logic [2:0]       mem_ldop,
  input  logic [31:0]      mem_alu,
  input  logic [31:0]      mem_rdata,
  input  logic [31:0]      mem_pc4,
  output logic             wb_rfwr,
  output logic [4:0]       wb_a3,
  output logic [31:0]      wb_wd,
  output logic             wb_fwd_en,
  output logic             wb_misalign,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [1:0] WDSEL_ALU  = 2'b00;
  localparam logic [1:0] WDSEL_LOAD = 2'b01;
  localparam logic [1:0] WDSEL_PC4  = 2'b10;

  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  // Pipeline register contents
  logic             valid_reg;
  logic             fresh_reg;
  logic             rfwr_reg;
  logic [4:0]       rd_reg;
  logic [1:0]       wdsel_reg;
  logic [2:0]       ldop_reg;
  logic [31:0]      alu_reg;
  logic [31:0]      rdata_reg;
  logic [31:0]      pc4_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Decoded load information
  logic [1:0]       off;
  logic [3:0][7:0]  byte_lane;
  logic [1:0][15:0] half_lane;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [31:0]      load_data;
  logic             is_half;
  logic             is_word;
  logic             misalign;
  logic             retire;

  // MEM/WB capture: flush beats stall; a held instruction is no longer fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      fresh_reg <= 1'b0;
      rfwr_reg  <= 1'b0;
      rd_reg    <= 5'd0;
      wdsel_reg <= 2'b00;
      ldop_reg  <= 3'b000;
      alu_reg   <= 32'd0;
      rdata_reg <= 32'd0;
      pc4_reg   <= 32'd0;
    end else if (flush) begin
      valid_reg <= 1'b0;
      fresh_reg <= 1'b0;
    end else if (stall) begin
      fresh_reg <= 1'b0;
    end else begin
      valid_reg <= mem_valid;
      fresh_reg <= mem_valid;
      rfwr_reg  <= mem_rfwr;
      rd_reg    <= mem_rd;
      wdsel_reg <= mem_wdsel;
      ldop_reg  <= mem_ldop;
      alu_reg   <= mem_alu;
      rdata_reg <= mem_rdata;
      pc4_reg   <= mem_pc4;
    end
  end

  // An instruction retires on the edge that ends its first WB cycle, even if
  // that edge also flushes, because it is leaving WB rather than entering.
  assign retire   = valid_reg & fresh_reg;
  assign cnt_next = cnt_reg + CNT_W'(1);

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (retire) begin
      cnt_reg <= cnt_next;
    end
  end

  assign off = alu_reg[1:0];

  // Byte lane n is the byte at address offset n within the word
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      if (BIG_ENDIAN) begin : g_be
        assign byte_lane[gi] = rdata_reg[31-8*gi -: 8];
      end else begin : g_le
        assign byte_lane[gi] = rdata_reg[8*gi +: 8];
      end
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      if (BIG_ENDIAN) begin : g_be
        assign half_lane[gi] = {byte_lane[2*gi], byte_lane[2*gi+1]};
      end else begin : g_le
        assign half_lane[gi] = {byte_lane[2*gi+1], byte_lane[2*gi]};
      end
    end
  endgenerate

  // Load-data extraction with sign/zero extension; unknown ops behave as lw
  always_comb begin
    sel_byte  = byte_lane[off];
    sel_half  = half_lane[off[1]];
    load_data = rdata_reg;
    case (ldop_reg)
      LD_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      LD_LBU:  load_data = {24'd0, sel_byte};
      LD_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      LD_LHU:  load_data = {16'd0, sel_half};
      default: load_data = rdata_reg;
    endcase
  end

  // Alignment check: words need off==0, halfwords need an even offset
  always_comb begin
    is_half  = (ldop_reg == LD_LH) || (ldop_reg == LD_LHU);
    is_word  = !is_half && (ldop_reg != LD_LB) && (ldop_reg != LD_LBU);
    misalign = valid_reg && (wdsel_reg == WDSEL_LOAD) &&
               ((is_word && (off != 2'b00)) || (is_half && off[0]));
  end

  // Writeback data select straight from the registered fields
  always_comb begin
    case (wdsel_reg)
      WDSEL_ALU:  wb_wd = alu_reg;
      WDSEL_LOAD: wb_wd = load_data;
      WDSEL_PC4:  wb_wd = pc4_reg;
      default:    wb_wd = 32'd0;
    endcase
  end

  // Forwarding only needs a real GPR result; the RF write additionally needs
  // the first WB cycle and an aligned access so it happens exactly once.
  assign wb_fwd_en   = valid_reg & rfwr_reg & (rd_reg != 5'd0);
  assign wb_rfwr     = wb_fwd_en & fresh_reg & ~misalign;
  assign wb_a3       = rd_reg;
  assign wb_misalign = misalign;
  assign retire_cnt  = cnt_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: three instances share stimulus
// (little-endian 32-bit counter, big-endian, and 4-bit counter).
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_rfwr;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wdsel;
  logic [2:0]  mem_ldop;
  logic [31:0] mem_alu;
  logic [31:0] mem_rdata;
  logic [31:0] mem_pc4;

  logic        wb_rfwr, be_rfwr, w4_rfwr;
  logic [4:0]  wb_a3, be_a3, w4_a3;
  logic [31:0] wb_wd, be_wd, w4_wd;
  logic        wb_fwd_en, be_fwd_en, w4_fwd_en;
  logic        wb_misalign, be_misalign, w4_misalign;
  logic [31:0] retire_cnt, be_cnt;
  logic [3:0]  w4_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic        pend    = 1'b0;

  typedef struct packed {
    logic        ca;
    logic        cw;
    logic        rfwr;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] wdbe;
    logic        fwd;
    logic        mis;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  mem_wb_stage #(.CNT_W(32), .BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_rfwr(mem_rfwr), .mem_rd(mem_rd),
    .mem_wdsel(mem_wdsel), .mem_ldop(mem_ldop), .mem_alu(mem_alu),
    .mem_rdata(mem_rdata), .mem_pc4(mem_pc4),
    .wb_rfwr(wb_rfwr), .wb_a3(wb_a3), .wb_wd(wb_wd), .wb_fwd_en(wb_fwd_en),
    .wb_misalign(wb_misalign), .retire_cnt(retire_cnt)
  );

  mem_wb_stage #(.CNT_W(32), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_rfwr(mem_rfwr), .mem_rd(mem_rd),
    .mem_wdsel(mem_wdsel), .mem_ldop(mem_ldop), .mem_alu(mem_alu),
    .mem_rdata(mem_rdata), .mem_pc4(mem_pc4),
    .wb_rfwr(be_rfwr), .wb_a3(be_a3), .wb_wd(be_wd), .wb_fwd_en(be_fwd_en),
    .wb_misalign(be_misalign), .retire_cnt(be_cnt)
  );

  mem_wb_stage #(.CNT_W(4), .BIG_ENDIAN(1'b0)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_rfwr(mem_rfwr), .mem_rd(mem_rd),
    .mem_wdsel(mem_wdsel), .mem_ldop(mem_ldop), .mem_alu(mem_alu),
    .mem_rdata(mem_rdata), .mem_pc4(mem_pc4),
    .wb_rfwr(w4_rfwr), .wb_a3(w4_a3), .wb_wd(w4_wd), .wb_fwd_en(w4_fwd_en),
    .wb_misalign(w4_misalign), .retire_cnt(w4_cnt)
  );

  // Single comparison point: counts and reports
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic ca, input logic cw, input logic rf,
                              input logic [4:0] a3, input logic [31:0] wd,
                              input logic [31:0] wdbe, input logic fwd, input logic mis);
    exp_t e;
    e.ca = ca; e.cw = cw; e.rfwr = rf; e.a3 = a3;
    e.wd = wd; e.wdbe = wdbe; e.fwd = fwd; e.mis = mis;
    return e;
  endfunction

  task automatic drive(input logic v, input logic rf, input logic [4:0] rd,
                       input logic [1:0] ws, input logic [2:0] lo,
                       input logic [31:0] a, input logic [31:0] pc);
    mem_valid = v; mem_rfwr = rf; mem_rd = rd; mem_wdsel = ws;
    mem_ldop = lo; mem_alu = a; mem_pc4 = pc;
  endtask

  // One clock edge; the counter model retires whatever was fresh in WB
  task automatic tick();
    logic nxt;
    nxt = rst_n && !flush && !stall && mem_valid;
    @(posedge clk);
    if (rst_n) begin
      exp_cnt = exp_cnt + 32'(pend);
      pend    = nxt;
    end
    #1;
  endtask

  task automatic compare_front();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      check_val("scoreboard.empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_val({t, ".rfwr"}, 32'(wb_rfwr), 32'(e.rfwr));
    check_val({t, ".fwd"},  32'(wb_fwd_en), 32'(e.fwd));
    check_val({t, ".mis"},  32'(wb_misalign), 32'(e.mis));
    check_val({t, ".aux"},
              32'({be_rfwr, be_fwd_en, be_misalign, w4_rfwr, w4_fwd_en, w4_misalign}),
              32'({e.rfwr, e.fwd, e.mis, e.rfwr, e.fwd, e.mis}));
    if (e.ca) check_val({t, ".a3"}, 32'({wb_a3, be_a3, w4_a3}), 32'({e.a3, e.a3, e.a3}));
    if (e.cw) begin
      check_val({t, ".wd"},    wb_wd, e.wd);
      check_val({t, ".wd_be"}, be_wd, e.wdbe);
      check_val({t, ".wd_w4"}, w4_wd, e.wd);
    end
    $display("[TB] txn %-10s rfwr=%0d a3=%0d wd=0x%08h wd_be=0x%08h fwd=%0d mis=%0d cnt=%0d",
             t, wb_rfwr, wb_a3, wb_wd, be_wd, wb_fwd_en, wb_misalign, retire_cnt);
  endtask

  task automatic cyc(input string tag, input exp_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    tick();
    compare_front();
  endtask

  task automatic chk_cnt(input string tag);
    check_val({tag, ".cnt"},    retire_cnt, exp_cnt);
    check_val({tag, ".cnt_be"}, be_cnt, exp_cnt);
    check_val({tag, ".cnt_w4"}, 32'(w4_cnt), exp_cnt & 32'hF);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    mem_rdata = 32'h80FF7F01;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.outs", {wb_rfwr, wb_fwd_en, wb_misalign, wb_a3}, 32'd0);
    check_val("rst.wd", wb_wd, 32'd0);
    chk_cnt("rst");
    rst_n = 1'b1;

    // 1: async reset in the middle of a cycle holding a valid write
    drive(1, 1, 5'd3, 2'b00, 3'b000, 32'h0000AAAA, 32'd0);
    cyc("pre_a", mk(1, 1, 1, 5'd3, 32'h0000AAAA, 32'h0000AAAA, 1, 0));
    drive(1, 1, 5'd7, 2'b00, 3'b000, 32'h00000055, 32'd0);
    cyc("pre_b", mk(1, 1, 1, 5'd7, 32'h00000055, 32'h00000055, 1, 0));
    chk_cnt("pre");
    #2;
    rst_n = 1'b0;
    exp_cnt = 32'd0;
    pend = 1'b0;
    idle();
    #1;
    check_val("arst.outs", {wb_rfwr, wb_fwd_en, wb_misalign, wb_a3}, 32'd0);
    check_val("arst.wd", wb_wd, 32'd0);
    chk_cnt("arst");
    #2;
    rst_n = 1'b1;
    cyc("post_idle", mk(1, 1, 0, 5'd0, 32'd0, 32'd0, 0, 0));
    drive(1, 1, 5'd5, 2'b00, 3'b000, 32'h00001234, 32'd0);
    cyc("post_rd5", mk(1, 1, 1, 5'd5, 32'h00001234, 32'h00001234, 1, 0));

    // 2: load extraction (rdata = 0x80FF7F01)
    drive(1, 1, 5'd10, 2'b01, 3'b001, 32'h00002001, 32'd0);
    cyc("lb_off1", mk(1, 1, 1, 5'd10, 32'h0000007F, 32'hFFFFFFFF, 1, 0));
    drive(1, 1, 5'd10, 2'b01, 3'b001, 32'h00002002, 32'd0);
    cyc("lb_off2", mk(1, 1, 1, 5'd10, 32'hFFFFFFFF, 32'h0000007F, 1, 0));
    drive(1, 1, 5'd10, 2'b01, 3'b010, 32'h00002003, 32'd0);
    cyc("lbu_off3", mk(1, 1, 1, 5'd10, 32'h00000080, 32'h00000001, 1, 0));
    drive(1, 1, 5'd10, 2'b01, 3'b011, 32'h00002002, 32'd0);
    cyc("lh_off2", mk(1, 1, 1, 5'd10, 32'hFFFF80FF, 32'h00007F01, 1, 0));
    drive(1, 1, 5'd10, 2'b01, 3'b100, 32'h00002000, 32'd0);
    cyc("lhu_off0", mk(1, 1, 1, 5'd10, 32'h00007F01, 32'h000080FF, 1, 0));
    drive(1, 1, 5'd11, 2'b01, 3'b000, 32'h00002000, 32'd0);
    cyc("lw", mk(1, 1, 1, 5'd11, 32'h80FF7F01, 32'h80FF7F01, 1, 0));
    drive(1, 1, 5'd11, 2'b01, 3'b111, 32'h00002000, 32'd0);
    cyc("ld_op7", mk(1, 1, 1, 5'd11, 32'h80FF7F01, 32'h80FF7F01, 1, 0));
    drive(1, 1, 5'd12, 2'b10, 3'b000, 32'h00000003, 32'h00400004);
    cyc("sel_pc4", mk(1, 1, 1, 5'd12, 32'h00400004, 32'h00400004, 1, 0));
    drive(1, 1, 5'd12, 2'b11, 3'b000, 32'h00000044, 32'h00400004);
    cyc("sel_rsv", mk(1, 1, 1, 5'd12, 32'd0, 32'd0, 1, 0));

    // 3: misaligned loads
    drive(1, 1, 5'd4, 2'b01, 3'b000, 32'h00001002, 32'd0);
    cyc("lw_mis", mk(1, 0, 0, 5'd4, 32'd0, 32'd0, 1, 1));
    drive(1, 1, 5'd4, 2'b01, 3'b011, 32'h00001001, 32'd0);
    cyc("lh_mis", mk(1, 0, 0, 5'd4, 32'd0, 32'd0, 1, 1));
    drive(1, 1, 5'd4, 2'b01, 3'b100, 32'h00001002, 32'd0);
    cyc("lhu_ok", mk(1, 1, 1, 5'd4, 32'h000080FF, 32'h00007F01, 1, 0));
    drive(1, 1, 5'd4, 2'b00, 3'b000, 32'h00001002, 32'd0);
    cyc("alu_odd", mk(1, 1, 1, 5'd4, 32'h00001002, 32'h00001002, 1, 0));
    chk_cnt("mis");

    // 4: stalled jal writes once, forwards throughout, retires once
    drive(1, 1, 5'd31, 2'b10, 3'b000, 32'h00000003, 32'h00400008);
    cyc("jal", mk(1, 1, 1, 5'd31, 32'h00400008, 32'h00400008, 1, 0));
    stall = 1'b1;
    drive(1, 1, 5'd2, 2'b00, 3'b000, 32'h00000099, 32'h00000099);
    for (int i = 0; i < 3; i++)
      cyc("jal_stall", mk(1, 1, 0, 5'd31, 32'h00400008, 32'h00400008, 1, 0));
    chk_cnt("stall");
    stall = 1'b0;

    // 5: flush wins over stall; rd=0 writer
    drive(1, 1, 5'd6, 2'b00, 3'b000, 32'h00000066, 32'd0);
    cyc("pre_flush", mk(1, 1, 1, 5'd6, 32'h00000066, 32'h00000066, 1, 0));
    stall = 1'b1; flush = 1'b1;
    drive(1, 1, 5'd9, 2'b00, 3'b000, 32'h00000099, 32'd0);
    cyc("flush", mk(0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 0));
    stall = 1'b0; flush = 1'b0;
    drive(1, 1, 5'd0, 2'b00, 3'b000, 32'h00000077, 32'd0);
    cyc("rd0", mk(1, 1, 0, 5'd0, 32'h00000077, 32'h00000077, 0, 0));
    idle();
    cyc("idle5", mk(1, 1, 0, 5'd0, 32'd0, 32'd0, 0, 0));
    chk_cnt("flush");

    // 6: counter wrap on the 4-bit instance
    rst_n = 1'b0;
    exp_cnt = 32'd0;
    pend = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 5'(i + 1), 2'b00, 3'b000, 32'(i), 32'd0);
      cyc("wrap", mk(1, 1, 0, 5'(i + 1), 32'(i), 32'(i), 0, 0));
    end
    idle();
    cyc("wrap_idle", mk(1, 1, 0, 5'd0, 32'd0, 32'd0, 0, 0));
    chk_cnt("wrap");
    check_val("wrap.w4_is_1", 32'(w4_cnt), 32'd1);
    check_val("wrap.cnt_is_17", retire_cnt, 32'd17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
